// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_subtractor_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of digits needed to cover one operand.
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width. One spare code so the counter can hold NDIG.
    function automatic int calc_cnt_w(input int width, input int digit);
        return $clog2(calc_ndig(width, digit) + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit_sub.sv
// Combinational DIGIT-wide ripple-borrow slice built from full-subtractor bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none (no handshake).
//
// Ports:
//   x, y   : DIGIT-bit minuend / subtrahend digits
//   bi     : borrow into the slice LSB
//   d      : DIGIT-bit difference digit
//   bo     : borrow out of the slice MSB
//   b_msb  : borrow into the slice MSB (used for signed overflow)
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             b_msb
);

    // chain[i] is the borrow into bit i; chain[DIGIT] is the borrow out.
    logic [DIGIT:0] chain;

    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]       = x[i] ^ y[i] ^ chain[i];
            chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
        end
    end

    assign bo    = chain[DIGIT];
    assign b_msb = chain[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - Bin over WIDTH bits, DIGIT bits per clock, borrow held in a flop.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge; one result per NDIG+2 cycles.
// Backpressure: in_ready only in IDLE; results held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (a, b, bin)
//   out_valid / out_ready : result handshake (diff, bout, ovf, zero)
//   diff : (a - b - bin) mod 2^WIDTH     bout : unsigned borrow out
//   ovf  : signed overflow               zero : diff == 0
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_subtractor: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    localparam int                NDIG     = calc_ndig(WIDTH, DIGIT);
    localparam int                CNT_W    = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NDIG - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [DIGIT-1:0]   slice_d;
    logic               slice_bo;
    logic               slice_bmsb;
    logic [WIDTH-1:0]   res_shift;

    digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .bi    (borrow_q),
        .d     (slice_d),
        .bo    (slice_bo),
        .b_msb (slice_bmsb)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
        res_shift = (res_q >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                res_d    = res_shift;
                borrow_d = slice_bo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Last digit: the slice holds the operand MSB, so its
                    // internal borrow-into-MSB gives the signed overflow.
                    bout_d  = slice_bo;
                    ovf_d   = slice_bmsb ^ slice_bo;
                    zero_d  = (res_shift == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // The result register is only rewritten during RUN, so it doubles as diff.
    assign diff = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three subtractor configurations (DIGIT 4, 1, 16) in lockstep.
// Latency: checked per instance against WIDTH/DIGIT.
// Backpressure: out_ready held low with in_valid/operands toggling in DONE.
module tb_serial_subtractor;

    localparam int W  = 16;
    localparam int NI = 3;
    localparam int DIGS [NI] = '{4, 1, 16};
    localparam int NDS  [NI] = '{4, 16, 1};

    typedef struct packed {
        logic         zero;
        logic         ovf;
        logic         bout;
        logic [W-1:0] diff;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [NI-1:0] ir, ov, bo, of, zr;
    logic [W-1:0]  df [NI];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [NI-1:0] pending = '0;
    logic [NI-1:0] seen    = '0;
    int            acc_cyc [NI];
    res_t          expq    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_subtractor #(.WIDTH(W), .DIGIT(DIGS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .bin       (bin),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .diff      (df[g]),
            .bout      (bo[g]),
            .ovf       (of[g]),
            .zero      (zr[g])
        );
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int   u;
        int   s;
        res_t r;
        u      = int'(x) - int'(y) - int'(bi);
        s      = int'($signed(x)) - int'($signed(y)) - int'(bi);
        r.diff = u[W-1:0];
        r.bout = (u < 0);
        r.ovf  = (s > 32767) || (s < -32768);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    task automatic chk(input bit ok, input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, k, act, req, $time);
        end
    endtask

    // Compare process: every falling edge, every instance.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    pending[k] = 1'b0;
                    seen[k]    = 1'b0;
                end else if (!pending[k]) begin
                    chk(ir[k] == 1'b1, "idle_in_ready", k, 32'(ir[k]), 1);
                    chk(ov[k] == 1'b0, "spurious_valid", k, 32'(ov[k]), 0);
                    if (in_valid) begin
                        pending[k] = 1'b1;
                        seen[k]    = 1'b0;
                        acc_cyc[k] = cyc;
                        expq[k]    = ref_sub(a, b, bin);
                    end
                end else begin
                    chk(ir[k] == 1'b0, "busy_in_ready", k, 32'(ir[k]), 0);
                    if (ov[k]) begin
                        if (!seen[k])
                            chk(cyc - acc_cyc[k] == NDS[k] + 1, "latency", k,
                                32'(cyc - acc_cyc[k] - 1), 32'(NDS[k]));
                        seen[k] = 1'b1;
                        chk(df[k] == expq[k].diff, "diff", k, 32'(df[k]), 32'(expq[k].diff));
                        chk(bo[k] == expq[k].bout, "bout", k, 32'(bo[k]), 32'(expq[k].bout));
                        chk(of[k] == expq[k].ovf,  "ovf",  k, 32'(of[k]), 32'(expq[k].ovf));
                        chk(zr[k] == expq[k].zero, "zero", k, 32'(zr[k]), 32'(expq[k].zero));
                        if (out_ready) pending[k] = 1'b0;
                    end else begin
                        chk(!seen[k], "valid_dropped", k, 0, 1);
                        chk(cyc - acc_cyc[k] < NDS[k] + 1, "late_valid", k,
                            32'(cyc - acc_cyc[k] - 1), 32'(NDS[k]));
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string nm);
        for (int k = 0; k < NI; k++) begin
            chk(ir[k] == 1'b1, {nm, "_in_ready"},  k, 32'(ir[k]), 1);
            chk(ov[k] == 1'b0, {nm, "_out_valid"}, k, 32'(ov[k]), 0);
            chk(df[k] == '0,   {nm, "_diff"},      k, 32'(df[k]), 0);
            chk(bo[k] == 1'b0, {nm, "_bout"},      k, 32'(bo[k]), 0);
            chk(of[k] == 1'b0, {nm, "_ovf"},       k, 32'(of[k]), 0);
            chk(zr[k] == 1'b0, {nm, "_zero"},      k, 32'(zr[k]), 0);
        end
    endtask

    task automatic wiggle(input bit wig);
        if (wig) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            bin      = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Entered and left at posedge+1 with all instances in IDLE.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                         input int bp, input bit wig);
        int t;
        a        = xa;
        b        = xb;
        bin      = xbin;
        in_valid = 1'b1;
        @(posedge clk) #1;
        t = 0;
        while (!(&ov) && t < 40) begin
            wiggle(wig);
            @(posedge clk) #1;
            t++;
        end
        chk(&ov, "done_timeout", -1, 32'(ov), 32'((1 << NI) - 1));
        for (int i = 0; i < bp; i++) begin
            wiggle(wig);
            @(posedge clk) #1;
        end
        out_ready = 1'b1;
        in_valid  = wig;
        @(posedge clk) #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Reset after two DIGIT=4 digits have been processed.
    task automatic reset_mid(input logic [W-1:0] xa, input logic [W-1:0] xb);
        a        = xa;
        b        = xb;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk) #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk) #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] x, y;
        int           sel;

        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed expectations pinning the reference model.
        chk(ref_sub(16'h1234, 16'h0234, 1'b0) == {1'b0, 1'b0, 1'b0, 16'h1000}, "model_1234", -1,
            32'(ref_sub(16'h1234, 16'h0234, 1'b0)), 32'h01000);
        chk(ref_sub(16'h0000, 16'h0001, 1'b0) == {1'b0, 1'b0, 1'b1, 16'hFFFF}, "model_0m1", -1,
            32'(ref_sub(16'h0000, 16'h0001, 1'b0)), 32'h1FFFF);
        chk(ref_sub(16'h8000, 16'h0001, 1'b0) == {1'b0, 1'b1, 1'b0, 16'h7FFF}, "model_8000", -1,
            32'(ref_sub(16'h8000, 16'h0001, 1'b0)), 32'h27FFF);
        chk(ref_sub(16'h0005, 16'h0004, 1'b1) == {1'b1, 1'b0, 1'b0, 16'h0000}, "model_zero", -1,
            32'(ref_sub(16'h0005, 16'h0004, 1'b1)), 32'h40000);

        do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0);

        // Backpressure with in_valid high through the hand-off cycle.
        do_op(16'hBEEF, 16'hC0DE, 1'b1, 3, 1'b1);
        do_op(16'hABCD, 16'h1234, 1'b1, 0, 1'b0);

        reset_mid(16'h4321, 16'h1234);
        do_op(16'h4321, 16'h1234, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            x   = W'($urandom);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       y = x;
                1:       y = x + 1'b1;
                2: begin x = 16'h8000; y = W'($urandom); end
                3: begin x = W'($urandom); y = 16'h8000; end
                default: y = W'($urandom);
            endcase
            if (n % 200 == 100) reset_mid(x, y);
            do_op(x, y, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
